// File: rtl/data_mem_controller_pkg.sv
// Shared types and width defaults for the LSU-to-data-memory controller.
package data_mem_controller_pkg;

  localparam int ADDR_BITS_DEF     = 8;
  localparam int DATA_BITS_DEF     = 8;
  localparam int NUM_CONSUMERS_DEF = 4;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } mem_state_e;

endpackage

// File: rtl/data_mem_controller_rr_arbiter.sv
// Combinational round-robin picker: lowest requester strictly after last_grant, wrapping.
module data_mem_controller_rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] last_grant_i,
  output logic            grant_valid_o,
  output logic [ID_W-1:0] grant_id_o
);

  // Walk offsets far-to-near so the nearest requester after last_grant is the final assignment.
  always_comb begin
    int idx;
    grant_valid_o = 1'b0;
    grant_id_o    = '0;
    idx           = 0;
    for (int off = N; off >= 1; off--) begin
      idx = (int'(last_grant_i) + off) % N;
      if (req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_id_o    = ID_W'(idx);
      end else begin
        grant_valid_o = grant_valid_o;
        grant_id_o    = grant_id_o;
      end
    end
  end

endmodule

// File: rtl/data_mem_controller.sv
// Arbitrates per-consumer LSU read/write channels onto one data-memory port,
// one transaction in flight, round-robin between consumers.
module data_mem_controller
  import data_mem_controller_pkg::*;
#(
  parameter int ADDR_BITS     = ADDR_BITS_DEF,
  parameter int DATA_BITS     = DATA_BITS_DEF,
  parameter int NUM_CONSUMERS = NUM_CONSUMERS_DEF
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int ID_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  mem_state_e                       state_q, state_d;
  logic [ID_W-1:0]                  grant_q, grant_d;
  logic [ID_W-1:0]                  last_grant_q, last_grant_d;
  logic [ADDR_BITS-1:0]             addr_q, addr_d;
  logic [DATA_BITS-1:0]             wdata_q, wdata_d;
  logic                             mem_rd_valid_q, mem_rd_valid_d;
  logic                             mem_wr_valid_q, mem_wr_valid_d;
  logic [NUM_CONSUMERS-1:0]         rd_ready_q, rd_ready_d;
  logic [NUM_CONSUMERS-1:0]         wr_ready_q, wr_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q, rd_data_d;

  logic [NUM_CONSUMERS-1:0] req_s;
  logic                     arb_valid_s;
  logic [ID_W-1:0]          arb_id_s;

  assign req_s = consumer_read_valid | consumer_write_valid;

  data_mem_controller_rr_arbiter #(
    .N    (NUM_CONSUMERS),
    .ID_W (ID_W)
  ) u_arb (
    .req_i         (req_s),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (arb_valid_s),
    .grant_id_o    (arb_id_s)
  );

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_grant_q   <= ID_W'(NUM_CONSUMERS - 1);
      addr_q         <= '0;
      wdata_q        <= '0;
      mem_rd_valid_q <= 1'b0;
      mem_wr_valid_q <= 1'b0;
      rd_ready_q     <= '0;
      wr_ready_q     <= '0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      mem_rd_valid_q <= mem_rd_valid_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      rd_ready_q     <= rd_ready_d;
      wr_ready_q     <= wr_ready_d;
      rd_data_q      <= rd_data_d;
    end
  end

  // Next-state and datapath updates; grants are only issued from IDLE.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    mem_rd_valid_d = mem_rd_valid_q;
    mem_wr_valid_d = mem_wr_valid_q;
    rd_ready_d     = rd_ready_q;
    wr_ready_d     = wr_ready_q;
    rd_data_d      = rd_data_q;
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          grant_d      = arb_id_s;
          last_grant_d = arb_id_s;
          // A consumer holding both requests is served read-first.
          if (consumer_read_valid[arb_id_s]) begin
            state_d        = READ_WAITING;
            addr_d         = consumer_read_address[int'(arb_id_s)*ADDR_BITS +: ADDR_BITS];
            mem_rd_valid_d = 1'b1;
          end else begin
            state_d        = WRITE_WAITING;
            addr_d         = consumer_write_address[int'(arb_id_s)*ADDR_BITS +: ADDR_BITS];
            wdata_d        = consumer_write_data[int'(arb_id_s)*DATA_BITS +: DATA_BITS];
            mem_wr_valid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) begin
          state_d             = READ_RELAYING;
          mem_rd_valid_d      = 1'b0;
          rd_ready_d[grant_q] = 1'b1;
          rd_data_d[int'(grant_q)*DATA_BITS +: DATA_BITS] = mem_read_data;
        end else begin
          state_d = READ_WAITING;
        end
      end
      WRITE_WAITING: begin
        if (mem_write_ready) begin
          state_d             = WRITE_RELAYING;
          mem_wr_valid_d      = 1'b0;
          wr_ready_d[grant_q] = 1'b1;
        end else begin
          state_d = WRITE_WAITING;
        end
      end
      READ_RELAYING: begin
        if (!consumer_read_valid[grant_q]) begin
          state_d    = IDLE;
          rd_ready_d = '0;
        end else begin
          state_d = READ_RELAYING;
        end
      end
      WRITE_RELAYING: begin
        if (!consumer_write_valid[grant_q]) begin
          state_d    = IDLE;
          wr_ready_d = '0;
        end else begin
          state_d = WRITE_RELAYING;
        end
      end
      default: begin
        state_d        = IDLE;
        mem_rd_valid_d = 1'b0;
        mem_wr_valid_d = 1'b0;
        rd_ready_d     = '0;
        wr_ready_d     = '0;
      end
    endcase
  end

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_read_data   = rd_data_q;
  assign consumer_write_ready = wr_ready_q;
  assign mem_read_valid       = mem_rd_valid_q;
  assign mem_read_address     = addr_q;
  assign mem_write_valid      = mem_wr_valid_q;
  assign mem_write_address    = addr_q;
  assign mem_write_data       = wdata_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Scoreboard bench for data_mem_controller with a 1-cycle (optionally stalled) memory model.
module tb_data_mem_controller;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    consumer_read_valid, consumer_read_ready;
  logic [N*AW-1:0] consumer_read_address;
  logic [N*DW-1:0] consumer_read_data;
  logic [N-1:0]    consumer_write_valid, consumer_write_ready;
  logic [N*AW-1:0] consumer_write_address;
  logic [N*DW-1:0] consumer_write_data;
  logic            mem_read_valid, mem_read_ready;
  logic [AW-1:0]   mem_read_address;
  logic [DW-1:0]   mem_read_data;
  logic            mem_write_valid, mem_write_ready;
  logic [AW-1:0]   mem_write_address;
  logic [DW-1:0]   mem_write_data;

  typedef struct {
    bit            is_wr;
    int            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          sb[$];
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  logic [AW-1:0] last_wr_addr;
  logic [DW-1:0] exp_rdata [N];
  int            rd_len [N];
  int            wr_len [N];
  logic          mem_stall;
  int            n_vec = 0;
  int            n_err = 0;
  int            rd_strobes = 0;

  data_mem_controller #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  // Memory: answers one cycle after it sees a request, unless stalled.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_read_ready  <= 1'b0;
      mem_write_ready <= 1'b0;
      mem_read_data   <= '0;
      last_wr_addr    <= '0;
      for (int a = 0; a < 256; a++) mem[a] <= init_val(8'(a));
    end else begin
      mem_read_ready  <= mem_read_valid && !mem_read_ready && !mem_stall;
      mem_write_ready <= mem_write_valid && !mem_write_ready;
      if (mem_read_valid && !mem_read_ready && !mem_stall)
        mem_read_data <= mem[mem_read_address];
      if (mem_write_valid && !mem_write_ready) begin
        mem[mem_write_address] <= mem_write_data;
        last_wr_addr           <= mem_write_address;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic req_read(input int id, input logic [AW-1:0] addr);
    txn_t t;
    consumer_read_address[id*AW +: AW] = addr;
    consumer_read_valid[id] = 1'b1;
    t.is_wr = 1'b0; t.id = id; t.addr = addr; t.data = ref_mem[addr];
    sb.push_back(t);
  endtask

  task automatic req_write(input int id, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    txn_t t;
    consumer_write_address[id*AW +: AW] = addr;
    consumer_write_data[id*DW +: DW]    = data;
    consumer_write_valid[id] = 1'b1;
    ref_mem[addr] = data;
    t.is_wr = 1'b1; t.id = id; t.addr = addr; t.data = data;
    sb.push_back(t);
  endtask

  // One clock: monitor consumer-side completions at the falling edge and drop served valids.
  task automatic tick();
    txn_t t;
    logic [N*DW-1:0] exp_packed;
    @(negedge clk);
    if (mem_read_valid) rd_strobes++;
    check_eq("one_hot_ready", 64'($countones({consumer_read_ready, consumer_write_ready}) <= 1), 64'd1);
    for (int i = 0; i < N; i++) begin
      if (consumer_read_ready[i]) begin
        if (rd_len[i] == 0) begin
          if (sb.size() == 0) check_eq("rd_sb_underflow", 64'(sb.size()), 64'd1);
          else begin
            t = sb.pop_front();
            check_eq("rd_kind", 64'(t.is_wr), 64'd0);
            check_eq("rd_order_id", 64'(i), 64'(t.id));
            check_eq("rd_data", 64'(consumer_read_data[i*DW +: DW]), 64'(t.data));
            exp_rdata[i] = t.data;
          end
          consumer_read_valid[i] = 1'b0;
        end
        rd_len[i]++;
      end else begin
        if (rd_len[i] != 0) check_eq("rd_ready_len", 64'(rd_len[i]), 64'd1);
        rd_len[i] = 0;
      end
      if (consumer_write_ready[i]) begin
        if (wr_len[i] == 0) begin
          if (sb.size() == 0) check_eq("wr_sb_underflow", 64'(sb.size()), 64'd1);
          else begin
            t = sb.pop_front();
            check_eq("wr_kind", 64'(t.is_wr), 64'd1);
            check_eq("wr_order_id", 64'(i), 64'(t.id));
            check_eq("wr_mem_addr", 64'(last_wr_addr), 64'(t.addr));
            check_eq("wr_mem_data", 64'(mem[t.addr]), 64'(t.data));
          end
          consumer_write_valid[i] = 1'b0;
        end
        wr_len[i]++;
      end else begin
        if (wr_len[i] != 0) check_eq("wr_ready_len", 64'(wr_len[i]), 64'd1);
        wr_len[i] = 0;
      end
    end
    for (int i = 0; i < N; i++) exp_packed[i*DW +: DW] = exp_rdata[i];
    check_eq("rdata_retained", 64'(consumer_read_data), 64'(exp_packed));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || (|consumer_read_valid) || (|consumer_write_valid)) && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (2) tick();
  endtask

  task automatic clear_tb_state();
    consumer_read_valid  = '0;
    consumer_write_valid = '0;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      exp_rdata[i] = '0; rd_len[i] = 0; wr_len[i] = 0;
    end
    for (int a = 0; a < 256; a++) ref_mem[a] = init_val(8'(a));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_tb_state();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    int base;
    reset = 1'b0;
    mem_stall = 1'b0;
    consumer_read_address  = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    clear_tb_state();
    repeat (2) @(negedge clk);
    check_eq("rst_consumer_outs", 64'({consumer_read_ready, consumer_write_ready, consumer_read_data}), 64'd0);
    check_eq("rst_mem_outs", 64'({mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data}), 64'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Single read with latency checks.
    req_read(0, 8'h10);
    tick();
    check_eq("t1_mem_valid", 64'(mem_read_valid), 64'd1);
    check_eq("t1_mem_addr", 64'(mem_read_address), 64'h10);
    check_eq("t1_no_early_ready", 64'(consumer_read_ready), 64'd0);
    tick();
    check_eq("t1_no_ready_e2", 64'(consumer_read_ready), 64'd0);
    tick();
    check_eq("t1_ready_e3", 64'(consumer_read_ready), 64'b0001);
    check_eq("t1_data", 64'(consumer_read_data[7:0]), 64'hA5);
    tick();
    check_eq("t1_ready_dropped", 64'(consumer_read_ready), 64'd0);
    wait_idle(50);

    // Single write from consumer 2.
    base = rd_strobes;
    req_write(2, 8'h20, 8'h3C);
    tick();
    check_eq("t2_mem_wvalid", 64'(mem_write_valid), 64'd1);
    check_eq("t2_mem_waddr", 64'(mem_write_address), 64'h20);
    check_eq("t2_mem_wdata", 64'(mem_write_data), 64'h3C);
    wait_idle(50);
    check_eq("t2_mem_content", 64'(mem[8'h20]), 64'h3C);
    check_eq("t2_no_read_strobe", 64'(rd_strobes - base), 64'd0);

    // Round robin after reset: 0,1,2,3 then 1,3.
    do_reset();
    for (int i = 0; i < N; i++) req_read(i, 8'(i));
    wait_idle(100);
    req_read(1, 8'h01);
    req_read(3, 8'h03);
    wait_idle(100);

    // Write then read to the same address, requested together.
    req_write(0, 8'h40, 8'h55);
    req_read(1, 8'h40);
    wait_idle(100);
    // Consumer holding both requests: read first, write later.
    req_read(2, 8'h40);
    req_write(2, 8'h41, 8'h77);
    wait_idle(100);

    // Stalled memory keeps the request stable.
    mem_stall = 1'b1;
    req_read(3, 8'h33);
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("t4_valid_held", 64'(mem_read_valid), 64'd1);
      check_eq("t4_addr_held", 64'(mem_read_address), 64'h33);
      check_eq("t4_no_ready", 64'(consumer_read_ready), 64'd0);
    end
    mem_stall = 1'b0;
    wait_idle(50);

    // Async reset in READ_WAITING, then consumer 0 must win over consumer 3.
    req_read(2, 8'h22);
    tick();
    check_eq("t6_in_waiting", 64'(mem_read_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_rst_consumer_outs", 64'({consumer_read_ready, consumer_write_ready, consumer_read_data}), 64'd0);
    check_eq("t6_rst_mem_outs", 64'({mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data}), 64'd0);
    clear_tb_state();
    @(negedge clk);
    reset = 1'b1;
    req_read(0, 8'h05);
    req_read(3, 8'h06);
    wait_idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
